// File: rtl/pic_control_logic.sv
// pic_control_logic: configuration, IRR/ISR/IMR, priority resolution and the
// 8086-style two-pulse INTA sequence of an 8259-compatible interrupt controller.
module pic_control_logic (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_data,
  input  logic [4:1] icw_stb,
  input  logic [3:1] ocw_stb,
  input  logic [7:0] ir,
  input  logic       inta_n,
  output logic       int_o,
  output logic [7:0] vector_o,
  output logic       vector_en,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [7:0] imr,
  output logic [7:0] rd_data
);

  typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;
  state_t state, state_n;

  logic       ltim, sngl, ic4, aeoi, aeoi_rot, ready, rd_sel, spur;
  logic [4:0] base;
  logic [2:0] lp, vlev;
  logic [7:0] ir_prev;
  logic       inta_prev;

  logic       inta_fall, inta_rise;
  logic       do_ack1, do_ack2, do_done;
  logic       ocw2_go;
  logic [2:0] ocw2_op;
  logic [3:0] pv, iv;
  logic       int_c;
  logic [7:0] irr_n, isr_n;
  logic [2:0] lp_n;

  // Returns {found, level} of the highest-priority set bit; level lowest+1 wins.
  function automatic logic [3:0] find_top(input logic [7:0] m, input logic [2:0] lowest);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = lowest + 3'(i) + 3'd1;
      if (m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lowest);
    return lvl - lowest - 3'd1;
  endfunction

  assign inta_fall = inta_prev & ~inta_n;
  assign inta_rise = ~inta_prev & inta_n;
  assign ocw2_go   = ready & ocw_stb[2];
  assign ocw2_op   = cmd_data[7:5];
  assign pv        = find_top(irr & ~imr, lp);
  assign iv        = find_top(isr, lp);
  assign rd_data   = rd_sel ? isr : irr;

  // Fully nested mode: a request only interrupts work of strictly lower priority.
  assign int_c = ready & (state == IDLE) & pv[3] &
                 (~iv[3] | (rank(pv[2:0], lp) < rank(iv[2:0], lp)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (inta_fall) state_n = ACK1;
      ACK1:    if (inta_fall) state_n = ACK2;
      ACK2:    if (inta_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (icw_stb[1]) state_n = IDLE;
  end

  always_comb begin
    do_ack1 = (state == IDLE) & inta_fall;
    do_ack2 = (state == ACK1) & inta_fall;
    do_done = (state == ACK2) & inta_rise;
  end

  // The ACK1 set is applied last so it wins over a same-cycle EOI.
  always_comb begin
    isr_n = isr;
    irr_n = irr;
    lp_n  = lp;
    for (int n = 0; n < 8; n++) begin
      if (ltim) irr_n[n] = ir[n];
      else      irr_n[n] = ir[n] & (irr[n] | ~ir_prev[n]);
    end
    if (do_done & aeoi & ~spur) begin
      isr_n[vlev] = 1'b0;
      if (aeoi_rot) lp_n = vlev;
    end
    if (ocw2_go) begin
      case (ocw2_op)
        3'b001: if (iv[3]) isr_n[iv[2:0]] = 1'b0;
        3'b011: isr_n[cmd_data[2:0]] = 1'b0;
        3'b101: if (iv[3]) begin
                  isr_n[iv[2:0]] = 1'b0;
                  lp_n = iv[2:0];
                end
        3'b111: begin
                  isr_n[cmd_data[2:0]] = 1'b0;
                  lp_n = cmd_data[2:0];
                end
        3'b110: lp_n = cmd_data[2:0];
        default: ;
      endcase
    end
    if (do_ack1 & pv[3]) begin
      isr_n[pv[2:0]] = 1'b1;
      irr_n[pv[2:0]] = 1'b0;
    end
  end

  // ICW3 only advances initialisation; cascading is unsupported so its contents are not kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ltim <= 1'b0; sngl <= 1'b0; ic4 <= 1'b0; base <= 5'd0;
      irr <= 8'h00; isr <= 8'h00; imr <= 8'h00;
      lp <= 3'd7; aeoi <= 1'b0; aeoi_rot <= 1'b0; ready <= 1'b0; rd_sel <= 1'b0;
      int_o <= 1'b0; vector_en <= 1'b0; vector_o <= 8'h00;
      vlev <= 3'd7; spur <= 1'b0;
      ir_prev <= 8'h00; inta_prev <= 1'b1;
    end else begin
      ir_prev   <= ir;
      inta_prev <= inta_n;
      if (icw_stb[1]) begin
        ltim <= cmd_data[3]; sngl <= cmd_data[1]; ic4 <= cmd_data[0];
        irr <= 8'h00; isr <= 8'h00; imr <= 8'h00;
        lp <= 3'd7; aeoi <= 1'b0; aeoi_rot <= 1'b0; ready <= 1'b0; rd_sel <= 1'b0;
        int_o <= 1'b0; vector_en <= 1'b0; vector_o <= 8'h00;
        vlev <= 3'd7; spur <= 1'b0;
      end else begin
        irr   <= irr_n;
        isr   <= isr_n;
        lp    <= lp_n;
        int_o <= int_c;
        if (icw_stb[2]) begin
          base <= cmd_data[7:3];
          if (sngl & ~ic4) ready <= 1'b1;
        end
        if (icw_stb[3] & ~ic4) ready <= 1'b1;
        if (icw_stb[4]) begin
          aeoi  <= cmd_data[1];
          ready <= 1'b1;
        end
        if (ready & ocw_stb[1]) imr <= cmd_data;
        if (ocw2_go & (ocw2_op == 3'b100)) aeoi_rot <= 1'b1;
        if (ocw2_go & (ocw2_op == 3'b000)) aeoi_rot <= 1'b0;
        if (ready & ocw_stb[3] & cmd_data[1]) rd_sel <= cmd_data[0];
        if (do_ack1) begin
          vlev <= pv[3] ? pv[2:0] : 3'd7;
          spur <= ~pv[3];
        end
        if (do_ack2) begin
          vector_en <= 1'b1;
          vector_o  <= {base, vlev};
        end
        if (do_done) begin
          vector_en <= 1'b0;
          vector_o  <= 8'h00;
        end
      end
    end
  end

endmodule
